// File: rtl/serial_sub_pkg.sv
// Shared FSM state type and state encodings for the bit-serial subtractor.
package serial_sub_pkg;

    localparam logic [1:0] ST_IDLE_ENC = 2'b00;
    localparam logic [1:0] ST_RUN_ENC  = 2'b01;
    localparam logic [1:0] ST_DONE_ENC = 2'b10;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE_ENC,
        RUN  = ST_RUN_ENC,
        DONE = ST_DONE_ENC
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational subtract cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial Diff = A - B - Bin, LSB first, one bit per clock behind a start handshake.
// Optional SERIAL_SUB_OVF_EN adds the signed overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  dsh_q, dsh_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              brw_q, brw_d;
    logic              bout_q, bout_d;
    logic              cell_d, cell_bout;
    logic              accept;
`ifdef SERIAL_SUB_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    full_subtractor u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (brw_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign start_ready = (state_q != RUN);
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign accept      = start_valid && start_ready;

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        dsh_d   = dsh_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                brw_d  = cell_bout;
                dsh_d  = {cell_d, dsh_q[WIDTH-1:1]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Final bit: publish result on the same edge that enters DONE.
                    state_d = DONE;
                    cnt_d   = '0;
                    diff_d  = {cell_d, dsh_q[WIDTH-1:1]};
                    bout_d  = cell_bout;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = brw_q ^ cell_bout;
`endif
                end
            end
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = RUN;
                    a_sh_d  = A;
                    b_sh_d  = B;
                    brw_d   = Bin;
                    dsh_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            dsh_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            dsh_q   <= dsh_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign Diff = diff_q;
    assign Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial ripple subtractor computing Diff = A - B - Bin, LSB first, one bit per clock.
Inverse-direction companion to the team's combinational ripple adder; trades latency for a single one-bit subtract cell.
Sits behind a valid/ready start handshake and signals completion with a done pulse.
Used in area-constrained datapaths next to the adder chain.

Parameters:
WIDTH, 4, operand and result width in bits (≥2)

Ports:
clk        input   1      single clock, rising edge
rst        input   1      asynchronous, active-high reset
start_valid input  1      request to start an operation
start_ready output 1      block can accept A/B/Bin this cycle
A          input   WIDTH  minuend, sampled on accept
B          input   WIDTH  subtrahend, sampled on accept
Bin        input   1      borrow-in, sampled on accept
Diff       output  WIDTH  result, valid when done=1, held until next accept
Bout       output  1      borrow-out (1 = unsigned A < B+Bin)
busy       output  1      operation in progress
done       output  1      one-cycle pulse, result valid

Behaviour:
- Reset (async assert, sync deassert-safe): state=IDLE; Diff=0, Bout=0, busy=0, done=0, start_ready=1; internal shift regs, borrow and counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE: start_ready=1, busy=0. On start_valid&&start_ready at an edge: latch A→a_sh, B→b_sh, Bin→brw, cnt=0; go to RUN.
- RUN: start_ready=0, busy=1. Each cycle:
  - d = a_sh[0]^b_sh[0]^brw.
  - brw_next = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&brw).
  - Shift a_sh and b_sh right; shift d into the MSB of a diff shift register.
  - cnt++.
  - When cnt==WIDTH-1, that edge goes to DONE and loads Diff/Bout from the final shift value and brw_next.
- DONE: done=1 for exactly one cycle, busy=0, start_ready=1. Accept here is legal (back-to-back): go to RUN. Otherwise go to IDLE.
- Latency: accept edge at T. Done is high in the cycle following edge T+WIDTH. Throughput is one op per WIDTH+1 cycles.
- Diff/Bout change only at the DONE-entry edge. They remain stable through IDLE and RUN of the next op.
- start_valid while in RUN is ignored. No queuing. A/B may change freely after accept.
- Counter width: $clog2(WIDTH). No wrap is possible beyond WIDTH-1.
- Reset mid-RUN: abort immediately. No done pulse. Outputs take reset values.
- Arithmetic is modulo 2^WIDTH; Bout is the unsigned borrow.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- When defined: adds output port ovf (1 bit), a signed two's-complement overflow flag.
  - ovf = borrow into MSB XOR Bout.
  - Updated with Diff at DONE entry; reset value 0; held like Diff.
- When undefined: port and logic are absent, with no other change.

Decomposition:
- Package serial_sub_pkg: state enum typedef (IDLE, RUN, DONE) and encoding constants.
- Sub-module full_subtractor: 1-bit combinational cell (a, b, bin → d, bout), instantiated once in RUN datapath. Mirrors the adder's full_adder.

Test Plan:
1. WIDTH=4, A=9, B=3, Bin=0 → after WIDTH+1 cycles done=1 for one cycle, Diff=6, Bout=0.
2. A=3, B=9, Bin=0 → Diff=0xA, Bout=1. Then A=0, B=0, Bin=1 → Diff=0xF, Bout=1.
3. Back-to-back: second start_valid held during DONE cycle (A=5, B=5) → accepted with no IDLE gap; next done shows Diff=0, Bout=0. start_valid pulsed mid-RUN is ignored (busy=1, start_ready=0).
4. Reset asserted 2 cycles into RUN → outputs immediately 0, start_ready=1, no done pulse. Fresh op (A=7, B=2) afterwards → Diff=5.
5. With SERIAL_SUB_OVF_EN: A=8 (−8), B=1 → Diff=7, ovf=1, Bout=0. A=2, B=1 → ovf=0.
6. Randomised 500 ops at WIDTH=8 against a reference model {Bout, Diff} = A−B−Bin, checking Diff stability between done pulses.
